// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM states and default operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDER_W_DEFAULT = 4;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full-adder cell; the serial adder pushes one operand bit pair through it per cycle.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder, LSB first, one bit per clock through a single full-adder cell.
// Optional two's-complement overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = ADDER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    // Handshake: start is accepted only in IDLE or DONE; done pulses for one cycle
    // N+1 cycles after acceptance, and sum/cout are valid from then until the next accepted start.
    localparam int CW = $clog2(N) + 1;

    state_t         state;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           fa_s;
    logic           fa_co;
    logic           last;

    fa_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= 1'b0;
`endif
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    // Sum bits enter at the MSB so the first (LSB) bit lands at bit 0 after N shifts.
                    sum   <= {fa_s, sum[N-1:1]};
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ fa_co;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
